crc32_stream_engine: RTL and testbench
======================================

Name: crc32_stream_engine

Overview:
- Sequential, parametrised CRC-32 engine (poly 0x04C11DB7, MSB-first, non-reflected) for the LMAC TX FCS-insert and RX FCS-check paths.
- Generalises the fixed 16-bit combinational CRC update to a DATA_W-bit streaming datapath with partial last beat, frame framing and abort.
- Offers a programmable init/final-XOR and a check mode with residue compare.
- Sits between the MAC framer/deframer and the XGMII-side datapath; one frame in flight at a time.

Parameters:
- DATA_W, 64, datapath width in bits; multiple of 8, range 8..256.
- CRC_INIT, 32'hFFFF_FFFF, CRC register value at start of frame.
- CRC_XOROUT, 32'hFFFF_FFFF, value XORed into the register to form crc_out.
- CRC_RESIDUE, 32'hC704_DD7B, register value after a good frame plus its FCS (check mode).
- LEN_W, 16, width of the frame byte counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat valid
- in_data  in  DATA_W  data; first byte on [DATA_W-1:DATA_W-8], MSB of each byte processed first
- in_last  in  1  final beat of frame
- in_nbytes  in  max(1,$clog2(DATA_W/8))  valid bytes on last beat, MSB-aligned; 0 = all bytes valid
- in_abort  in  1  discard current frame
- check_mode  in  1  0 = generate, 1 = check; sampled on the first beat of a frame
- in_ready  out  1  engine accepts a beat
- crc_valid  out  1  one-cycle pulse, result valid
- crc_out  out  32  CRC register XOR CRC_XOROUT
- crc_ok  out  1  check mode: register == CRC_RESIDUE; generate mode: 0
- frame_len  out  LEN_W  bytes in completed frame, saturating at all-ones

Behaviour:
- Reset values: crc_valid=0, crc_out=0, crc_ok=0, frame_len=0, in_ready=1, CRC register=CRC_INIT, FSM=IDLE.
- Beat transfer: in_valid && in_ready.
- in_ready is deasserted only in the single DONE cycle.
- FSM states and transitions:
  - IDLE: transfer -> ACTIVE (or DONE if in_last). On this first beat the register loads the update seeded with CRC_INIT; the mode is latched from check_mode.
  - ACTIVE: transfer -> update the register seeded with its current value; in_last -> DONE.
  - DONE: crc_valid=1 for exactly one cycle; crc_out, crc_ok and frame_len are held until the next DONE. Register reloads CRC_INIT; next state IDLE.
- Latency: crc_valid is asserted 1 cycle after the last-beat transfer.
- Back-to-back frames therefore incur 1 bubble cycle.
- Update rule:
  - Byte-serial fold over the valid bytes, highest byte first.
  - Each byte step is equivalent to 8 serial LFSR shifts.
  - Non-last beats fold all DATA_W/8 bytes.
  - Last beat folds in_nbytes bytes (0 means all); unused low bytes are ignored regardless of value.
  - in_nbytes is ignored when in_last=0.
- Byte counter:
  - Adds the folded byte count per beat and saturates at 2^LEN_W-1.
  - Transferred to frame_len in DONE, then cleared.
- Abort: in_abort in IDLE or ACTIVE (with or without a beat) returns to IDLE and reloads CRC_INIT and counter. No crc_valid; outputs keep their previous values.
- Abort priority: in_abort beats in_last in the same cycle. in_abort in DONE is ignored.
- Reset mid-frame: all state returns to reset values immediately; no pulse is produced.
- check_mode changes mid-frame have no effect.

Decomposition:
- Package crc32_pkg holds:
  - CRC32_POLY.
  - Default init/xorout/residue constants.
  - crc_state_t (IDLE/ACTIVE/DONE enum).
  - Function crc32_byte(crc, byte) implementing the 8-step LFSR.
- One sub-module, crc32_fold: combinational.
  - Inputs: seed, DATA_W data, nbytes. Output: next CRC.
  - Built as a chain of crc32_byte with a per-byte select mux.
- The top holds the FSM, register, counter and outputs.

Test Plan:
- DATA_W=64, generate mode, ASCII "123456789" as beat 0x3132333435363738 then last beat 0x39xx.. with in_nbytes=1 -> crc_valid 1 cycle later, crc_out=0xFC891918, frame_len=9.
- Same frame at DATA_W=16 (5 beats, last in_nbytes=1) and DATA_W=8 -> identical crc_out=0xFC891918. Cross-check the 16-bit case against the existing 16-bit update equations beat by beat.
- Check mode, "123456789" followed by FCS bytes FC 89 19 18 (DATA_W=64: 2 beats, last in_nbytes=5) -> crc_ok=1, frame_len=13. Flip one data bit -> crc_ok=0.
- Abort on beat 1 of a 3-beat frame, then a clean "123456789" frame -> single crc_valid with 0xFC891918 and no pulse for the aborted frame.
- Back-to-back single-beat frames with in_valid held high -> in_ready low exactly in each DONE cycle, one crc_valid per frame. Garbage in unused bytes with in_nbytes<8 does not change the result.
- Assert rst_n low mid-frame -> outputs at reset values asynchronously, no crc_valid; the next frame computes correctly from CRC_INIT.

Source files
------------

// File: rtl/crc32_pkg.sv
// crc32_pkg: shared CRC-32 constants, FSM state type and the byte-wide LFSR step.
// Polynomial 0x04C11DB7, MSB-first, non-reflected. Init and xorout default to
// all-ones; the residue is the register value left behind by a good frame + FCS.
package crc32_pkg;

  localparam logic [31:0] CRC32_POLY            = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT_DEFAULT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_XOROUT_DEFAULT  = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC32_RESIDUE_DEFAULT = 32'hC704_DD7B;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } crc_state_t;

  // Eight serial LFSR shifts, data bit 7 enters first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_fold.sv
// crc32_fold: combinational fold of up to DATA_W/8 bytes into a CRC-32 register.
// Ports: seed (starting register), data (first byte in the top lane), nbytes
// (bytes to fold, 0 = all) -> crc_next (folded register), nbytes_used (count folded).
module crc32_fold
  import crc32_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int NB_W   = 3
) (
  input  logic [31:0]       seed,
  input  logic [DATA_W-1:0] data,
  input  logic [NB_W-1:0]   nbytes,
  output logic [31:0]       crc_next,
  output logic [NB_W:0]     nbytes_used
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CW     = NB_W + 1;

  // nbytes == 0 encodes a full beat; the extra bit holds NBYTES itself.
  assign nbytes_used = (nbytes == '0) ? CW'(NBYTES) : {1'b0, nbytes};

  // Byte chain, highest lane first; lanes past nbytes_used pass the CRC through
  // untouched so their contents never matter.
  always_comb begin
    logic [31:0] c;
    c = seed;
    for (int k = 0; k < NBYTES; k++) begin
      if (CW'(k) < nbytes_used) c = crc32_byte(c, data[DATA_W-1-8*k -: 8]);
    end
    crc_next = c;
  end

endmodule

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine: streaming CRC-32 generate/check engine, one frame in flight.
// Ports: in_valid/in_data/in_last/in_nbytes/in_abort/check_mode beat input with
// in_ready; crc_valid pulse with crc_out, crc_ok and frame_len held until the next result.
module crc32_stream_engine
  import crc32_pkg::*;
#(
  parameter int          DATA_W      = 64,
  parameter logic [31:0] CRC_INIT    = crc32_pkg::CRC32_INIT_DEFAULT,
  parameter logic [31:0] CRC_XOROUT  = crc32_pkg::CRC32_XOROUT_DEFAULT,
  parameter logic [31:0] CRC_RESIDUE = crc32_pkg::CRC32_RESIDUE_DEFAULT,
  parameter int          LEN_W       = 16
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   in_valid,
  input  logic [DATA_W-1:0]                                      in_data,
  input  logic                                                   in_last,
  input  logic [((DATA_W/8 > 1) ? $clog2(DATA_W/8) : 1)-1:0]     in_nbytes,
  input  logic                                                   in_abort,
  input  logic                                                   check_mode,
  output logic                                                   in_ready,
  output logic                                                   crc_valid,
  output logic [31:0]                                            crc_out,
  output logic                                                   crc_ok,
  output logic [LEN_W-1:0]                                       frame_len
);

  localparam int NB_W = (DATA_W / 8 > 1) ? $clog2(DATA_W / 8) : 1;
  localparam int LW1  = LEN_W + 1;

  crc_state_t       state, state_nx;
  logic [31:0]      crc_reg;
  logic [LEN_W-1:0] byte_cnt;
  logic             mode_q;

  logic             xfer;
  logic             load_init;
  logic             fold_en;
  logic             finish;

  logic [31:0]      fold_seed;
  logic [NB_W-1:0]  fold_nbytes;
  logic [31:0]      fold_crc;
  logic [NB_W:0]    fold_used;
  logic [LEN_W:0]   cnt_sum;
  logic [LEN_W-1:0] cnt_next;
  logic             mode_eff;

  assign in_ready = (state != DONE);
  assign xfer     = in_valid && in_ready;

  // First beat is always seeded from CRC_INIT; in_nbytes only matters on the last beat.
  assign fold_seed   = (state == IDLE) ? CRC_INIT : crc_reg;
  assign fold_nbytes = in_last ? in_nbytes : '0;

  crc32_fold #(
    .DATA_W (DATA_W),
    .NB_W   (NB_W)
  ) u_fold (
    .seed        (fold_seed),
    .data        (in_data),
    .nbytes      (fold_nbytes),
    .crc_next    (fold_crc),
    .nbytes_used (fold_used)
  );

  // Saturating byte count: the carry-out bit flags overflow.
  assign cnt_sum  = {1'b0, byte_cnt} + LW1'(fold_used);
  assign cnt_next = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];

  // A single-beat frame has not latched its mode yet, so use the live input.
  assign mode_eff = (state == IDLE) ? check_mode : mode_q;

  always_comb begin
    state_nx  = state;
    load_init = 1'b0;
    fold_en   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, ACTIVE: begin
        // Abort wins over a coincident last beat and discards any beat with it.
        if (in_abort) begin
          state_nx  = IDLE;
          load_init = 1'b1;
        end else if (xfer) begin
          fold_en  = 1'b1;
          finish   = in_last;
          state_nx = in_last ? DONE : ACTIVE;
        end
      end
      DONE: begin
        state_nx  = IDLE;
        load_init = 1'b1;
      end
      default: begin
        state_nx  = IDLE;
        load_init = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc_reg  <= CRC_INIT;
      byte_cnt <= '0;
      mode_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load_init) begin
        crc_reg  <= CRC_INIT;
        byte_cnt <= '0;
      end else if (fold_en) begin
        crc_reg  <= fold_crc;
        byte_cnt <= cnt_next;
      end
      if (state == IDLE && xfer) mode_q <= check_mode;
    end
  end

  // Results are captured on the last-beat edge so they line up with the
  // crc_valid pulse in the DONE cycle, then held until the next frame completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_valid <= 1'b0;
      crc_out   <= '0;
      crc_ok    <= 1'b0;
      frame_len <= '0;
    end else begin
      crc_valid <= finish;
      if (finish) begin
        crc_out   <= fold_crc ^ CRC_XOROUT;
        crc_ok    <= mode_eff && (fold_crc == CRC_RESIDUE);
        frame_len <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_crc32_stream_engine.sv
// tb_crc32_stream_engine: directed bench for the CRC-32 engine at 64-bit and 16-bit widths.
// Expected results are queued when a last beat is driven and popped on each crc_valid.
module tb_crc32_stream_engine;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [31:0] crc;
    logic        ok;
    logic [15:0] len;
  } exp_t;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_last, in_abort, check_mode, in_ready;
  logic [63:0] in_data;
  logic [2:0]  in_nbytes;
  logic        crc_valid, crc_ok;
  logic [31:0] crc_out;
  logic [15:0] frame_len;

  logic        v16, l16, ab16, cm16, r16, cv16, ok16;
  logic [15:0] d16;
  logic [0:0]  nb16;
  logic [31:0] co16;
  logic [3:0]  fl16;

  int checks   = 0;
  int failures = 0;
  exp_t exp_q[$];
  exp_t exp16_q[$];
  logic [31:0] last_crc;
  logic [15:0] last_len;

  crc32_stream_engine #(.DATA_W(64), .LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_nbytes(in_nbytes), .in_abort(in_abort), .check_mode(check_mode), .in_ready(in_ready),
    .crc_valid(crc_valid), .crc_out(crc_out), .crc_ok(crc_ok), .frame_len(frame_len)
  );

  crc32_stream_engine #(.DATA_W(16), .LEN_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_data(d16), .in_last(l16),
    .in_nbytes(nb16), .in_abort(ab16), .check_mode(cm16), .in_ready(r16),
    .crc_valid(cv16), .crc_out(co16), .crc_ok(ok16), .frame_len(fl16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference over the whole message; returns the raw register.
  function automatic logic [31:0] ref_reg(input bq_t m);
    logic [31:0] r;
    logic        fb;
    r = 32'hFFFF_FFFF;
    foreach (m[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[31] ^ m[i][b];
        r  = r << 1;
        if (fb) r = r ^ 32'h04C1_1DB7;
      end
    end
    return r;
  endfunction

  function automatic exp_t mk(input logic [31:0] c, input logic ok, input int len);
    exp_t e;
    e.crc = c;
    e.ok  = ok;
    e.len = 16'(len);
    return e;
  endfunction

  function automatic bq_t ascii9();
    bq_t m;
    for (int i = 0; i < 9; i++) m.push_back(8'h31 + 8'(i));
    return m;
  endfunction

  // One clock; outputs sampled 1 time unit after the edge and scored.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (crc_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        failures++; $error("FAIL pulse64_unexpected observed crc_out=%h expected no pulse", crc_out);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (crc_out === e.crc) else begin
          failures++; $error("FAIL crc64 observed=%h expected=%h", crc_out, e.crc);
        end
        checks++;
        assert (crc_ok === e.ok) else begin
          failures++; $error("FAIL ok64 observed=%b expected=%b", crc_ok, e.ok);
        end
        checks++;
        assert (frame_len === e.len) else begin
          failures++; $error("FAIL len64 observed=%0d expected=%0d", frame_len, e.len);
        end
        last_crc = e.crc;
        last_len = e.len;
      end
    end
    if (cv16 === 1'b1) begin
      checks++;
      assert (exp16_q.size() > 0) else begin
        failures++; $error("FAIL pulse16_unexpected observed crc_out=%h expected no pulse", co16);
      end
      if (exp16_q.size() > 0) begin
        e = exp16_q.pop_front();
        checks++;
        assert (co16 === e.crc) else begin
          failures++; $error("FAIL crc16 observed=%h expected=%h", co16, e.crc);
        end
        checks++;
        assert (fl16 === e.len[3:0]) else begin
          failures++; $error("FAIL len16 observed=%0d expected=%0d", fl16, e.len[3:0]);
        end
      end
    end
  endtask

  // Clock until the presented beat is accepted, bounded.
  task automatic beat_xfer(input bit w16);
    bit xf;
    int g;
    g = 0;
    do begin
      xf = w16 ? r16 : in_ready;
      tick();
      g++;
    end while (!xf && g < 8);
    checks++;
    assert (xf) else begin
      failures++; $error("FAIL beat_accept observed ready=0 expected ready=1 within 8 cycles");
    end
  endtask

  task automatic send_frame(input bq_t m, input bit chk, input bit garb, input bit hold, input exp_t e);
    int n;
    int nbeats;
    logic [63:0] d;
    n = m.size();
    nbeats = (n + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      d = garb ? {$urandom, $urandom} : 64'd0;
      for (int k = 0; k < 8; k++) if (b * 8 + k < n) d[63-8*k -: 8] = m[b*8+k];
      in_valid   = 1'b1;
      in_data    = d;
      in_last    = (b == nbeats - 1);
      in_nbytes  = in_last ? 3'(n % 8) : (garb ? 3'($urandom) : 3'd0);
      check_mode = (b == 0) ? chk : ~chk;
      if (in_last) exp_q.push_back(e);
      beat_xfer(1'b0);
    end
    checks++;
    assert (crc_valid === 1'b1) else begin
      failures++; $error("FAIL latency observed crc_valid=%b expected=1", crc_valid);
    end
    checks++;
    assert (in_ready === 1'b0) else begin
      failures++; $error("FAIL ready_in_done observed=%b expected=0", in_ready);
    end
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic send16(input bq_t m, input exp_t e);
    int n;
    int nbeats;
    n = m.size();
    nbeats = (n + 1) / 2;
    for (int b = 0; b < nbeats; b++) begin
      d16 = 16'($urandom);
      d16[15:8] = m[2*b];
      if (2 * b + 1 < n) d16[7:0] = m[2*b+1];
      v16  = 1'b1;
      l16  = (b == nbeats - 1);
      nb16 = l16 ? 1'(n % 2) : 1'($urandom);
      if (l16) exp16_q.push_back(e);
      beat_xfer(1'b1);
    end
    v16 = 1'b0;
    l16 = 1'b0;
  endtask

  initial begin
    bq_t m, mf;
    logic [31:0] r;
    in_valid = 0; in_data = '0; in_last = 0; in_nbytes = '0; in_abort = 0; check_mode = 0;
    v16 = 0; d16 = '0; l16 = 0; nb16 = '0; ab16 = 0; cm16 = 0;
    last_crc = '0; last_len = '0;
    rst_n = 1'b0;
    #12;
    checks++; assert (crc_valid === 1'b0) else begin failures++; $error("FAIL rst_valid observed=%b expected=0", crc_valid); end
    checks++; assert (crc_out === 32'h0) else begin failures++; $error("FAIL rst_crc observed=%h expected=0", crc_out); end
    checks++; assert (crc_ok === 1'b0) else begin failures++; $error("FAIL rst_ok observed=%b expected=0", crc_ok); end
    checks++; assert (frame_len === 16'd0) else begin failures++; $error("FAIL rst_len observed=%0d expected=0", frame_len); end
    checks++; assert (in_ready === 1'b1) else begin failures++; $error("FAIL rst_ready observed=%b expected=1", in_ready); end
    rst_n = 1'b1;
    tick();

    // Golden generate frame, then again with garbage in unused lanes and nbytes.
    send_frame(ascii9(), 1'b0, 1'b0, 1'b0, mk(32'hFC89_1918, 1'b0, 9));
    tick();
    send_frame(ascii9(), 1'b0, 1'b1, 1'b0, mk(32'hFC89_1918, 1'b0, 9));
    tick();

    // Check mode: good FCS, then one flipped data bit.
    m = ascii9();
    m.push_back(8'hFC); m.push_back(8'h89); m.push_back(8'h19); m.push_back(8'h18);
    send_frame(m, 1'b1, 1'b1, 1'b0, mk(32'h38FB_2284, 1'b1, 13));
    tick();
    mf = m;
    mf[0] = mf[0] ^ 8'h01;
    send_frame(mf, 1'b1, 1'b0, 1'b0, mk(ref_reg(mf) ^ 32'hFFFF_FFFF, 1'b0, 13));
    tick();

    // Aborts: with a beat mid-frame, coincident with last, and with no beat.
    in_valid = 1; in_data = {$urandom, $urandom}; in_last = 0; beat_xfer(1'b0);
    in_abort = 1; in_data = {$urandom, $urandom}; beat_xfer(1'b0);
    in_abort = 0; in_valid = 0;
    repeat (3) tick();
    in_valid = 1; in_data = {$urandom, $urandom}; in_last = 1; in_nbytes = 3'd3; in_abort = 1;
    beat_xfer(1'b0);
    in_abort = 0; in_valid = 0; in_last = 0;
    repeat (3) tick();
    in_valid = 1; in_data = {$urandom, $urandom}; beat_xfer(1'b0);
    in_valid = 0; in_abort = 1; tick(); in_abort = 0;
    repeat (2) tick();
    checks++; assert (crc_out === last_crc) else begin failures++; $error("FAIL abort_hold_crc observed=%h expected=%h", crc_out, last_crc); end
    checks++; assert (frame_len === last_len) else begin failures++; $error("FAIL abort_hold_len observed=%0d expected=%0d", frame_len, last_len); end
    send_frame(ascii9(), 1'b0, 1'b0, 1'b0, mk(32'hFC89_1918, 1'b0, 9));
    tick();

    // Back-to-back frames with in_valid held high.
    for (int f = 0; f < 5; f++) begin
      m = {};
      for (int i = 0; i < int'($urandom_range(1, 8)); i++) m.push_back(8'($urandom));
      send_frame(m, 1'b0, 1'b1, 1'b1, mk(ref_reg(m) ^ 32'hFFFF_FFFF, 1'b0, m.size()));
    end
    // Multi-beat check-mode frame carrying its own FCS, still back-to-back.
    m = {};
    for (int i = 0; i < 17; i++) m.push_back(8'($urandom));
    r = ref_reg(m) ^ 32'hFFFF_FFFF;
    for (int i = 3; i >= 0; i--) m.push_back(r[8*i +: 8]);
    send_frame(m, 1'b1, 1'b1, 1'b0, mk(32'h38FB_2284, 1'b1, 21));
    tick();

    // Reset mid-frame: asynchronous clear, no pulse, then a clean frame.
    in_valid = 1; in_data = 64'h3132_3334_3536_3738; in_last = 0; beat_xfer(1'b0);
    in_valid = 0;
    #3 rst_n = 1'b0;
    #1;
    checks++; assert (crc_out === 32'h0) else begin failures++; $error("FAIL midrst_crc observed=%h expected=0", crc_out); end
    checks++; assert (frame_len === 16'd0) else begin failures++; $error("FAIL midrst_len observed=%0d expected=0", frame_len); end
    checks++; assert (crc_valid === 1'b0) else begin failures++; $error("FAIL midrst_valid observed=%b expected=0", crc_valid); end
    checks++; assert (in_ready === 1'b1) else begin failures++; $error("FAIL midrst_ready observed=%b expected=1", in_ready); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send_frame(ascii9(), 1'b0, 1'b0, 1'b0, mk(32'hFC89_1918, 1'b0, 9));
    tick();

    // 16-bit datapath: golden frame, then a 20-byte frame saturating a 4-bit length.
    send16(ascii9(), mk(32'hFC89_1918, 1'b0, 9));
    repeat (2) tick();
    m = {};
    for (int i = 0; i < 20; i++) m.push_back(8'($urandom));
    send16(m, mk(ref_reg(m) ^ 32'hFFFF_FFFF, 1'b0, 15));
    repeat (3) tick();

    checks++; assert (exp_q.size() == 0) else begin failures++; $error("FAIL missing64 observed pending=%0d expected=0", exp_q.size()); end
    checks++; assert (exp16_q.size() == 0) else begin failures++; $error("FAIL missing16 observed pending=%0d expected=0", exp16_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
